// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU front end: instruction field layout,
// decoded opcode values and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W = 19;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned OP_MSB  = 18;
    localparam int unsigned OP_LSB  = 15;
    localparam int unsigned OP_W    = OP_MSB - OP_LSB + 1;

    localparam logic [OP_W-1:0] OP_JMP  = 4'b0011;
    localparam logic [OP_W-1:0] OP_BR   = 4'b0100;
    localparam logic [OP_W-1:0] OP_CALL = 4'b0111;
    localparam logic [OP_W-1:0] OP_RET  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, instruction memory and the datapath.
//   master : environment side (control inputs, memory read data)
//   slave  : the sequencer (fetch address, issued instruction, status)
interface fetch_sequencer_if;
    import cpu_pkg::*;

    logic               start_i;
    logic [ADDR_W-1:0]  start_addr_i;
    logic               stop_i;
    logic               stall_i;
    logic               cond_i;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  instr_addr;
    logic [INSTR_W-1:0] ir_o;
    logic               ir_valid_o;
    logic               busy_o;
    logic               fault_o;

    modport master (
        output start_i, start_addr_i, stop_i, stall_i, cond_i, instruction,
        input  instr_addr, ir_o, ir_valid_o, busy_o, fault_o
    );

    modport slave (
        input  start_i, start_addr_i, stop_i, stall_i, cond_i, instruction,
        output instr_addr, ir_o, ir_valid_o, busy_o, fault_o
    );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO, RAS_DEPTH entries of ADDR_W bits.
//   i_clr          : empty the stack (pointer to 0)
//   i_push / i_pop : never asserted together; ignored when full / empty
//   i_data         : address to push
//   o_top_c        : current top of stack (combinational)
//   o_full_c       : pointer equals RAS_DEPTH
//   o_empty_c      : pointer equals 0
module ret_stack
    import cpu_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_top_c,
    output logic              o_full_c,
    output logic              o_empty_c
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full_c  = (r_ptr == PTR_W'(RAS_DEPTH));
    assign o_empty_c = (r_ptr == '0);
    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;
    assign w_wr_idx  = IDX_W'(r_ptr);
    assign w_rd_idx  = IDX_W'(r_ptr - PTR_W'(1));
    assign o_top_c   = r_mem[w_rd_idx];

    // Pointer counts occupied entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - PTR_W'(1);
        end
    end

    // Storage has no reset; contents are only read below the pointer.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-flow controller: owns the PC, fetches from a combinational
// instruction memory, registers the issued word and resolves JMP/BR/CALL/RET
// with a hardware return-address stack.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : control inputs, memory address/data, IR and status outputs
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.slave   bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_ir_valid;
    logic               r_busy;
    logic               r_fault;

    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [INSTR_W-1:0] w_ir_nxt;
    logic               w_ir_valid_nxt;
    logic               w_busy_nxt;
    logic               w_fault_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_clr;

    logic [OP_W-1:0]    w_opcode;
    logic [ADDR_W-1:0]  w_target;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_run_go;
    logic               w_ras_err;
    logic [ADDR_W-1:0]  w_ras_top;
    logic               w_ras_full;
    logic               w_ras_empty;

    assign w_opcode = bus.instruction[OP_MSB:OP_LSB];
    assign w_target = bus.instruction[ADDR_W-1:0];
    assign w_pc_inc = r_pc + ADDR_W'(1);

    // A fetch is consumed only in RUN with neither stop nor stall.
    assign w_run_go  = (r_state == ST_RUN) && !bus.stop_i && !bus.stall_i;
    assign w_ras_err = w_run_go &&
                       (((w_opcode == OP_CALL) && w_ras_full) ||
                        ((w_opcode == OP_RET)  && w_ras_empty));

    ret_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_pc_inc),
        .o_top_c   (w_ras_top),
        .o_full_c  (w_ras_full),
        .o_empty_c (w_ras_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stop outranks stall and stack errors.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ras_err) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of PC, IR and status plus stack controls.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ir_valid_nxt = r_ir_valid;
        w_fault_nxt    = r_fault;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_clr          = 1'b0;
        w_busy_nxt     = (w_state_nxt == ST_RUN);
        case (r_state)
            ST_IDLE: begin
                w_ir_valid_nxt = 1'b0;
                if (bus.start_i) begin
                    w_pc_nxt = bus.start_addr_i;
                    w_clr    = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stop_i) begin
                    w_ir_valid_nxt = 1'b0;
                end else if (bus.stall_i) begin
                    w_ir_valid_nxt = r_ir_valid;
                end else if (w_ras_err) begin
                    w_ir_valid_nxt = 1'b0;
                    w_fault_nxt    = 1'b1;
                end else begin
                    w_ir_nxt       = bus.instruction;
                    w_ir_valid_nxt = 1'b1;
                    case (w_opcode)
                        OP_JMP:  w_pc_nxt = w_target;
                        OP_BR:   w_pc_nxt = bus.cond_i ? w_target : w_pc_inc;
                        OP_CALL: begin
                            w_push   = 1'b1;
                            w_pc_nxt = w_target;
                        end
                        OP_RET: begin
                            w_pop    = 1'b1;
                            w_pc_nxt = w_ras_top;
                        end
                        default: w_pc_nxt = w_pc_inc;
                    endcase
                end
            end
            default: begin
                w_fault_nxt = r_fault;
            end
        endcase
    end

    // PC, IR and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign bus.instr_addr = r_pc;
    assign bus.ir_o       = r_ir;
    assign bus.ir_valid_o = r_ir_valid;
    assign bus.busy_o     = r_busy;
    assign bus.fault_o    = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs push the expected
// (next fetch address, issued word) per valid cycle; a monitor pops and
// compares whenever ir_valid_o is high. Status is checked directly.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [4:0]  addr;
        logic [18:0] ir;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [18:0] mem [32];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RAS_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.instruction = mem[bus.instr_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    // Monitor: every valid issue cycle consumes one expectation.
    always @(negedge clk) begin
        if (bus.ir_valid_o === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: ir_o=%h addr=%0d, required no valid issue",
                         bus.ir_o, bus.instr_addr);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.ir_o !== e.ir || bus.instr_addr !== e.addr) begin
                    errors++;
                    $display("FAIL issue: ir_o=%h addr=%0d, required ir_o=%h addr=%0d",
                             bus.ir_o, bus.instr_addr, e.ir, e.addr);
                end
            end
        end
    end

    function automatic logic [18:0] mk(input logic [3:0] op, input logic [14:0] low);
        return {op, low};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushx(input logic [4:0] a, input logic [18:0] ir);
        exp_t e;
        e.addr = a;
        e.ir   = ir;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        chk({name, "_addr"},  32'(bus.instr_addr), 0);
        chk({name, "_ir"},    32'(bus.ir_o), 0);
        chk({name, "_valid"}, 32'(bus.ir_valid_o), 0);
        chk({name, "_busy"},  32'(bus.busy_o), 0);
        chk({name, "_fault"}, 32'(bus.fault_o), 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 19'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.stall_i = 1'b0;
        bus.cond_i  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_at(input logic [4:0] a);
        bus.start_addr_i = a;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic stop_run();
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.start_addr_i = 5'd0;
        bus.stop_i  = 1'b0;
        bus.stall_i = 1'b0;
        bus.cond_i  = 1'b0;
        clear_mem();
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;

        // Sequential run from 0.
        for (int i = 0; i < 4; i++) mem[i] = mk(4'b0101, 15'(32'h100 + i));
        start_at(5'd0);
        chk("seq_enter_addr",  32'(bus.instr_addr), 0);
        chk("seq_enter_busy",  32'(bus.busy_o), 1);
        chk("seq_enter_valid", 32'(bus.ir_valid_o), 0);
        pushx(5'd1, 19'h28100);
        pushx(5'd2, 19'h28101);
        pushx(5'd3, 19'h28102);
        pushx(5'd4, 19'h28103);
        repeat (4) tick();
        stop_run();
        chk("seq_stop_busy",  32'(bus.busy_o), 0);
        chk("seq_stop_valid", 32'(bus.ir_valid_o), 0);
        chk("seq_stop_addr",  32'(bus.instr_addr), 4);

        // CALL 16 / RET back to 3, then RET on the now-empty stack faults.
        do_reset();
        clear_mem();
        mem[2]  = mk(4'b0111, 15'd16);
        mem[16] = mk(4'b0001, 15'h0AB);
        mem[17] = mk(4'b1000, 15'd0);
        mem[3]  = mk(4'b0101, 15'h033);
        mem[4]  = mk(4'b1000, 15'd0);
        start_at(5'd2);
        pushx(5'd16, 19'h38010);
        pushx(5'd17, 19'h080AB);
        pushx(5'd3,  19'h40000);
        pushx(5'd4,  19'h28033);
        repeat (4) tick();
        tick();
        chk("under_fault", 32'(bus.fault_o), 1);
        chk("under_valid", 32'(bus.ir_valid_o), 0);
        chk("under_addr",  32'(bus.instr_addr), 4);
        chk("under_busy",  32'(bus.busy_o), 0);
        start_at(5'd9);
        chk("under_start_fault", 32'(bus.fault_o), 1);
        chk("under_start_addr",  32'(bus.instr_addr), 4);
        stop_run();
        chk("under_stop_fault", 32'(bus.fault_o), 1);
        do_reset();
        check_reset("under_rst");

        // BR taken / not taken, opcode 1111 wraps 31 -> 0, JMP.
        clear_mem();
        mem[5]  = mk(4'b0100, 15'd19);
        mem[19] = mk(4'b0101, 15'h019);
        mem[6]  = mk(4'b0101, 15'h006);
        mem[31] = mk(4'b1111, 15'h005);
        mem[0]  = mk(4'b0011, 15'd10);
        bus.cond_i = 1'b1;
        start_at(5'd5);
        pushx(5'd19, 19'h20013);
        pushx(5'd20, 19'h28019);
        tick();
        tick();
        bus.stop_i  = 1'b1;
        bus.stall_i = 1'b1;
        tick();
        bus.stop_i  = 1'b0;
        bus.stall_i = 1'b0;
        chk("prio_busy",  32'(bus.busy_o), 0);
        chk("prio_valid", 32'(bus.ir_valid_o), 0);
        chk("prio_addr",  32'(bus.instr_addr), 20);
        bus.cond_i = 1'b0;
        start_at(5'd5);
        pushx(5'd6, 19'h20013);
        pushx(5'd7, 19'h28006);
        tick();
        tick();
        stop_run();
        chk("br_nt_addr", 32'(bus.instr_addr), 7);
        start_at(5'd31);
        pushx(5'd0,  19'h78005);
        pushx(5'd10, 19'h1800A);
        tick();
        tick();
        stop_run();
        chk("wrap_jmp_addr", 32'(bus.instr_addr), 10);

        // Stall three cycles at PC=4.
        do_reset();
        clear_mem();
        for (int i = 3; i < 8; i++) mem[i] = mk(4'b0101, 15'(32'h200 + i));
        start_at(5'd3);
        pushx(5'd4, 19'h28203);
        tick();
        bus.stall_i = 1'b1;
        pushx(5'd4, 19'h28203);
        pushx(5'd4, 19'h28203);
        pushx(5'd4, 19'h28203);
        repeat (3) tick();
        bus.stall_i = 1'b0;
        pushx(5'd5, 19'h28204);
        pushx(5'd6, 19'h28205);
        tick();
        tick();
        bus.stall_i = 1'b1;
        bus.stop_i  = 1'b1;
        tick();
        bus.stall_i = 1'b0;
        bus.stop_i  = 1'b0;
        chk("stall_stop_valid", 32'(bus.ir_valid_o), 0);
        chk("stall_stop_addr",  32'(bus.instr_addr), 6);

        // Five nested CALLs overflow a 4-deep stack.
        do_reset();
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = mk(4'b0111, 15'(i + 1));
        start_at(5'd0);
        pushx(5'd1, 19'h38001);
        pushx(5'd2, 19'h38002);
        pushx(5'd3, 19'h38003);
        pushx(5'd4, 19'h38004);
        repeat (4) tick();
        tick();
        chk("over_fault", 32'(bus.fault_o), 1);
        chk("over_valid", 32'(bus.ir_valid_o), 0);
        chk("over_addr",  32'(bus.instr_addr), 4);
        chk("over_busy",  32'(bus.busy_o), 0);
        start_at(5'd0);
        chk("over_start_fault", 32'(bus.fault_o), 1);
        chk("over_start_addr",  32'(bus.instr_addr), 4);
        do_reset();
        check_reset("over_rst");

        // Reset in the middle of a CALL sequence.
        clear_mem();
        mem[2]  = mk(4'b0111, 15'd16);
        mem[16] = mk(4'b0001, 15'h0AB);
        mem[17] = mk(4'b1000, 15'd0);
        start_at(5'd2);
        pushx(5'd16, 19'h38010);
        tick();
        rst_n = 1'b0;
        tick();
        check_reset("midcall_rst");
        rst_n = 1'b1;
        start_at(5'd17);
        tick();
        chk("midcall_ret_fault", 32'(bus.fault_o), 1);
        chk("midcall_ret_addr",  32'(bus.instr_addr), 17);

        tick();
        chk("sb_drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-flow controller for the 19-bit CPU. It owns the program counter and drives the 5-bit address of the 32-entry combinational instruction memory. Each cycle it captures the returned word into an instruction register for the datapath, and it resolves JMP, conditional BR, CALL and RET itself using a small hardware return-address stack. It sits between the instruction memory and decode/execute. Multi-cycle datapath operations hold it through a stall input.

## Interface
- `RAS_DEPTH`, default 4: number of return-address stack entries (2..8).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start_i` in 1: in IDLE, begin execution at `start_addr_i`.
- `start_addr_i` in 5: first fetch address.
- `stop_i` in 1: in RUN, return to IDLE.
- `stall_i` in 1: datapath busy; freeze the sequencer.
- `cond_i` in 1: branch condition flag from the datapath, sampled in the BR fetch cycle.
- `instruction` in 19: word from instruction memory at `instr_addr` (combinational, same cycle).
- `instr_addr` out 5: fetch address, equal to the PC.
- `ir_o` out 19: issued instruction.
- `ir_valid_o` out 1: `ir_o` holds a valid instruction for execute.
- `busy_o` out 1: state is RUN.
- `fault_o` out 1: stack overflow or underflow occurred; sticky.

## Operation
- Opcode is `instruction[18:15]`. The target is `instruction[4:0]`. Decoded opcodes:
  - 0011 JMP
  - 0100 BR (taken if `cond_i`=1)
  - 0111 CALL
  - 1000 RET
- All other opcodes, including 0000, are sequential: next PC = PC+1, mod 32. 31 wraps to 0 with no flag.
- FSM states: IDLE, RUN, FAULT.
- IDLE:
  - `ir_valid_o`=0 and PC holds.
  - When `start_i`=1: PC ← `start_addr_i`, RAS pointer ← 0, go to RUN.
  - `stop_i` and `stall_i` are ignored in IDLE.
- RUN, `stall_i`=0, each cycle:
  - `ir_o` ← `instruction`, `ir_valid_o` ← 1.
  - PC ← next PC:
    - JMP: target.
    - BR: target if `cond_i`, else PC+1.
    - CALL: push PC+1 (mod 32), then target.
    - RET: pop.
    - Other: PC+1.
- RUN, `stall_i`=1: PC, `ir_o`, `ir_valid_o` and the stack all hold, and `instruction` is ignored.
- RUN, `stop_i`=1 (has priority over `stall_i`): go to IDLE, `ir_valid_o` ← 0, PC holds.
- CALL with the stack full (pointer = `RAS_DEPTH`): no push, PC holds at the CALL address. Go to FAULT with `fault_o` ← 1 and `ir_valid_o` ← 0.
- RET with the stack empty: same behaviour as a full-stack CALL.
- FAULT: all outputs hold, `start_i` and `stop_i` are ignored. Only `rst_n` exits FAULT.
- Reset during any state overrides everything at that edge.
- Reset values:
  - `instr_addr`=0, `ir_o`=0
  - `ir_valid_o`=0, `busy_o`=0, `fault_o`=0
  - RAS pointer 0, state IDLE
  - Stack contents are don't-care.

## Timing
- Fetch-to-issue latency is 1 cycle. The word addressed in cycle N appears on `ir_o` after edge N.
- Taken control flow has zero bubbles. The target is fetched in the cycle after the JMP/BR/CALL/RET fetch.
- CALL, RET and BR are themselves issued on `ir_o` like any other instruction. The datapath treats them as NOPs.
- The first valid `ir_o` appears 2 edges after `start_i` is sampled: edge 1 enters RUN, edge 2 latches the first word.
- `stall_i` takes effect at the edge where it is sampled high. `ir_o` is stable for the whole stall.
- `busy_o` is a registered decode of the state, so it rises at the same edge that enters RUN.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants: `OP_JMP`=4'b0011, `OP_BR`=4'b0100, `OP_CALL`=4'b0111, `OP_RET`=4'b1000
  - field widths: `INSTR_W`=19, `ADDR_W`=5, `OP_MSB`=18, `OP_LSB`=15
  - the FSM state encoding.
- One sub-module, `ret_stack`. It is a `RAS_DEPTH` × 5-bit LIFO with push, pop, full and empty, plus the pointer. It has no simultaneous push and pop.
- The top level contains the FSM, PC, IR and next-PC mux.

## Test plan
- Sequential run: memory [0..3] are 0101 words, `start_i` with address 0 → `instr_addr` sequence 0,1,2,3. `ir_o` lags by 1 and `ir_valid_o` rises on the 2nd edge.
- CALL/RET: [2]=0111…0010000 (CALL 16), [16]=0001…, [17]=1000 RET → addresses 2,16,17,3 and the stack returns to empty.
- BR: [5]=0100…0010011 → `cond_i`=1 gives next address 19; `cond_i`=0 gives 6. Wrap case: an ordinary word at 31 gives next address 0.
- Stall: assert `stall_i` for 3 cycles at PC=4 → `instr_addr`=4 and `ir_o` are unchanged for 3 cycles, then the sequence resumes at 5.
- Overflow/underflow: 5 nested CALLs with `RAS_DEPTH`=4 → the 5th gives `fault_o`=1, `ir_valid_o`=0, and PC held at the 5th CALL address. Separately, RET from an empty stack also faults. `start_i` does not clear the fault; only `rst_n` low does.
- Control priority: `stop_i` and `stall_i` both high in RUN → IDLE next edge. Reset pulsed mid-CALL → all outputs return to their reset values.
